// File: rtl/div_unit.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// stalls the pipeline while busy and holds the finished result until EX advances.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   op_a_i,
   input  logic [WIDTH-1:0]   op_b_i,
   input  logic               annul_i,
   input  logic               ex_hold_i,
   output logic               stallreq_o,
   output logic               ready_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] divisor_q;
   logic             neg_quo_q, neg_rem_q;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] rem_trial, quo_next, quo_fix, rem_fix;
   logic             last;

   // quo_q shifts the remaining dividend bits out of its top while quotient
   // bits enter at the bottom; rem_q already holds the next bit shifted in.
   always_comb begin
      a_neg     = signed_i & op_a_i[WIDTH-1];
      b_neg     = signed_i & op_b_i[WIDTH-1];
      abs_a     = a_neg ? -op_a_i : op_a_i;
      abs_b     = b_neg ? -op_b_i : op_b_i;
      diff      = rem_q - {1'b0, divisor_q};
      fits      = ~diff[WIDTH];
      rem_trial = fits ? diff[WIDTH-1:0] : rem_q[WIDTH-1:0];
      quo_next  = {quo_q[WIDTH-2:0], fits};
      quo_fix   = neg_quo_q ? -quo_next : quo_next;
      rem_fix   = neg_rem_q ? -rem_trial : rem_trial;
      last      = (count_q == CW'(WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      if (annul_i) begin
         state_d = FREE;
      end else begin
         case (state_q)
            FREE:    if (start_i) state_d = (op_b_i == '0) ? BYZERO : ON;
            BYZERO:  state_d = END;
            ON:      if (last) state_d = END;
            END:     if (!ex_hold_i) state_d = FREE;
            default: state_d = FREE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FREE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         ready_o <= (state_d == END);
         case (state_q)
            FREE: begin
               if (state_d == ON) begin
                  rem_q     <= {{WIDTH{1'b0}}, abs_a[WIDTH-1]};
                  quo_q     <= {abs_a[WIDTH-2:0], 1'b0};
                  divisor_q <= abs_b;
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  count_q   <= '0;
               end
            end
            ON: begin
               rem_q   <= {rem_trial, quo_q[WIDTH-1]};
               quo_q   <= quo_next;
               count_q <= count_q + CW'(1);
               if (state_d == END) result_o <= {rem_fix, quo_fix};
            end
            BYZERO: begin
               if (state_d == END) result_o <= '0;
            end
            default: ;
         endcase
      end
   end

   assign stallreq_o = start_i & ~annul_i & (state_q != END);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random divides compared
// against a plain-arithmetic reference model, checked cycle by cycle.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, signed_i, annul_i, ex_hold_i;
   logic [31:0] op_a_i, op_b_i;
   logic        stallreq_o, ready_o;
   logic [63:0] result_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [63:0] last_res = '0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .annul_i    (annul_i),
      .ex_hold_i  (ex_hold_i),
      .stallreq_o (stallreq_o),
      .ready_o    (ready_o),
      .result_o   (result_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h at %0t", tag, got, exp, $time);
      end
   endtask

   // {remainder, quotient} computed with 64-bit arithmetic; C-style truncation
   function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered just after a rising edge with the unit in FREE.
   task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned hold, input bit chain);
      logic [63:0] exp;
      int unsigned lat;
      exp       = ref_div(sg, a, b);
      lat       = (b == 32'd0) ? 2 : 33;
      start_i   = 1'b1;
      signed_i  = sg;
      op_a_i    = a;
      op_b_i    = b;
      annul_i   = 1'b0;
      ex_hold_i = 1'($urandom_range(0, 1));
      for (int unsigned k = 0; k < lat; k++) begin
         @(negedge clk);
         check("busy_stall", stallreq_o, 1);
         check("busy_ready", ready_o, 0);
         step();
         op_a_i    = $urandom;
         op_b_i    = $urandom;
         signed_i  = 1'($urandom_range(0, 1));
         ex_hold_i = 1'($urandom_range(0, 1));
      end
      for (int unsigned j = 0; j <= hold; j++) begin
         ex_hold_i = (j < hold);
         @(negedge clk);
         check("done_ready", ready_o, 1);
         check("done_stall", stallreq_o, 0);
         check("result", result_o, exp);
         step();
      end
      last_res  = exp;
      ex_hold_i = 1'b0;
      if (!chain) begin
         start_i = 1'b0;
         @(negedge clk);
         check("idle_ready", ready_o, 0);
         check("idle_stall", stallreq_o, 0);
         step();
      end
   endtask

   task automatic do_annul(input int unsigned at);
      start_i   = 1'b1;
      signed_i  = 1'b0;
      op_a_i    = 32'd100;
      op_b_i    = 32'd7;
      annul_i   = 1'b0;
      ex_hold_i = 1'b0;
      for (int unsigned k = 0; k < at; k++) begin
         @(negedge clk);
         check("pre_annul_stall", stallreq_o, 1);
         step();
      end
      annul_i = 1'b1;
      @(negedge clk);
      check("annul_stall", stallreq_o, 0);
      step();
      annul_i = 1'b0;
      start_i = 1'b0;
      for (int unsigned k = 0; k < 40; k++) begin
         @(negedge clk);
         check("annul_ready", ready_o, 0);
         step();
      end
      check("annul_keep_result", result_o, last_res);
   endtask

   initial begin
      rst_n     = 1'b0;
      start_i   = 1'b0;
      signed_i  = 1'b0;
      annul_i   = 1'b0;
      ex_hold_i = 1'b0;
      op_a_i    = '0;
      op_b_i    = '0;
      #2;
      check("rst_ready", ready_o, 0);
      check("rst_result", result_o, 0);
      check("rst_stall_low", stallreq_o, 0);
      start_i = 1'b1;
      #1;
      check("rst_stall_comb", stallreq_o, 1);
      start_i = 1'b0;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
      check("divu_100_7", last_res, 64'h00000002_0000000E);
      do_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
      do_div(1'b1, 32'd5, 32'd0, 0, 1'b0);
      do_div(1'b0, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0);

      do_annul(10);
      do_annul(0);

      do_div(1'b0, 32'd100, 32'd7, 3, 1'b0);
      do_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

      do_div(1'b1, 32'hFFFFFF9C, 32'd7, 0, 1'b1);
      do_div(1'b0, 32'd12345, 32'd0, 1, 1'b1);
      do_div(1'b1, 32'd77, 32'hFFFFFFF6, 2, 1'b0);

      // asynchronous reset mid-operation, asserted between clock edges
      start_i  = 1'b1;
      signed_i = 1'b0;
      op_a_i   = 32'd100;
      op_b_i   = 32'd7;
      for (int unsigned k = 0; k < 20; k++) step();
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", ready_o, 0);
      check("async_rst_result", result_o, 0);
      start_i = 1'b0;
      step();
      #3;
      rst_n = 1'b1;
      step();
      do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);

      for (int unsigned i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         case ($urandom_range(0, 4))
            0:       a = 32'h80000000;
            1:       a = $urandom_range(0, 1000);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = 32'hFFFFFFFF;
            3:       b = $urandom_range(1, 255);
            default: b = $urandom;
         endcase
         do_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      start_i = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
